thresh_pwm_ctrl: RTL and testbench
==================================

Name: thresh_pwm_ctrl

Overview:
- Generates the VIH_PWM and VIL_PWM threshold signals that configure the analog front end's comparator thresholds.
- Accepts 8-bit threshold writes from the command/config logic and applies them only at PWM period boundaries.
- Enforces VIL < VIH.
- Raises thresh_rdy once the AFE has had one complete PWM period at the new duty, so capture logic knows the CHxL/CHxH outputs are trustworthy.

Parameters:
- CNT_W, 10: PWM period counter width; period = 2^CNT_W clocks (1024), matching the AFE's 10-bit duty counter.
- VAL_W, 8: threshold width; high time = val << (CNT_W-VAL_W) clocks.
- VIH_RST, 8'hAA: VIH value after reset (0.66 full scale).
- VIL_RST, 8'h55: VIL value after reset (0.33 full scale).

Ports:
- clk  in  1  system/sample clock, same clock the AFE samples on.
- rst  in  1  synchronous, active-high reset.
- wr_VIH  in  1  one-cycle strobe: request new VIH from VIH_data.
- VIH_data  in  8  requested VIH value.
- wr_VIL  in  1  one-cycle strobe: request new VIL from VIL_data.
- VIL_data  in  8  requested VIL value.
- VIH_PWM  out  1  PWM to AFE; duty encodes VIH.
- VIL_PWM  out  1  PWM to AFE; duty encodes VIL.
- VIH_cur  out  8  VIH value currently driving VIH_PWM.
- VIL_cur  out  8  VIL value currently driving VIL_PWM.
- thresh_rdy  out  1  both channels settled.
- wr_err  out  1  one-cycle pulse: write rejected.

Behaviour:
- Single clock domain, one clock.
- Reset is synchronous and active-high on rst, which takes priority over all other inputs.
- Reset values:
  - cnt=0, VIH_PWM=0, VIL_PWM=0, wr_err=0, thresh_rdy=0.
  - Active and pending values: VIH=VIH_RST, VIL=VIL_RST.
  - Both channel FSMs in SETTLE.
- Period counter cnt [CNT_W-1:0] is free-running, +1 per clk, and wraps 1023->0. "Boundary" = cycle with cnt==1023.
- PWM output is registered: X_PWM <= (cnt < {X_act,2'b00}).
  - High for exactly 4*X_act consecutive clocks starting the cycle after cnt==0 is presented.
  - Low for the remaining 1024-4*X_act clocks.
  - val 0xFF: high 1020, low 4.
- Write clamp: a data value of 0 is stored as 1. A value of 0 would leave the PWM constant low, the AFE would never see a posedge, and the threshold would never update.
- Ordering check, performed against the effective other value (pending if a write is pending, else active):
  - wr_VIL with clamp(VIL_data) >= VIH_eff -> rejected, wr_err=1 next cycle, no state change.
  - wr_VIH with clamp(VIH_data) <= VIL_eff -> rejected likewise.
  - Simultaneous wr_VIH and wr_VIL: the pair is checked against each other. Both are accepted or both rejected; single wr_err pulse.
- Per-channel FSM (identical instances for VIH and VIL):
  - IDLE (settled): accepted write -> pending<=data, go PEND.
  - PEND: accepted write overwrites pending (last write wins). At boundary: active<=pending, go SETTLE. A write on the boundary cycle itself is loaded into pending after the transfer and stays PEND.
  - SETTLE: accepted write -> go PEND. Next boundary with no write -> IDLE.
- Because the transfer happens on the boundary cycle, the new duty starts on the very next period.
- Active values transfer only at boundaries, so a partial period never mixes old and new duty.
- thresh_rdy is registered: 1 when both FSMs are IDLE, else 0. Any accepted write drops it on the next cycle.
- After reset, thresh_rdy rises at the end of the first full period (cycle after cnt first reaches 1023).
- VIH_cur and VIL_cur reflect active values, updated on the boundary transfer.
- Reset mid-period: outputs drop to 0 next cycle, cnt restarts at 0, pending writes are discarded.

Decomposition:
- Shared package thresh_pkg holds:
  - PWM_PERIOD=1024, CNT_W, VAL_W.
  - VIH_RST=8'hAA, VIL_RST=8'h55.
  - Channel state enum {IDLE, PEND, SETTLE}.
- One sub-module, thresh_pwm_chan: the pending/active registers, the FSM and the output compare. It takes cnt, the boundary flag and the accept strobe; it is instantiated twice.
- The top level holds cnt, the ordering check and thresh_rdy/wr_err.

Test Plan:
- Reset, run 2100 clocks -> VIH_PWM high 680 clocks/period, VIL_PWM high 340; thresh_rdy rises on cycle 1025 after reset release. Loopback AFE captures VIH=0xAA, VIL=0x55.
- At cnt=300, wr_VIL with VIL_data=0x40 -> current period keeps 340-clk duty; next period 256-clk duty; VIL_cur=0x40 after boundary; thresh_rdy low from the write until one period after the boundary. AFE VIL=0x40.
- wr_VIL with VIL_data=0xB0 while VIH=0xAA -> wr_err one pulse, VIL_cur unchanged, thresh_rdy unaffected. Simultaneous wr_VIH=0xC0 plus wr_VIL=0xB0 -> both accepted.
- wr_VIH 0xE0 then 0xF0 in the same period -> only 0xF0 applied (960-clk high). wr_VIL with VIL_data=0 -> VIL_cur=0x01, 4-clk pulse.
- Write landing exactly on the cnt==1023 cycle, and a write during SETTLE -> state goes PEND, applied at the following boundary, thresh_rdy stays low until one period after that.
- Assert rst at cnt=500 with a pending write -> PWMs low next cycle, reset values restored, pending write discarded.

Source files
------------

// File: rtl/thresh_pkg.sv
// Shared constants, channel state type and write-value clamp for the
// VIH/VIL threshold PWM controller.
package thresh_pkg;

  localparam int CNT_W      = 10;
  localparam int VAL_W      = 8;
  localparam int PWM_PERIOD = 1 << CNT_W;

  localparam logic [VAL_W-1:0] VIH_RST = 8'hAA;
  localparam logic [VAL_W-1:0] VIL_RST = 8'h55;

  // IDLE: settled, PEND: new value waiting for a boundary,
  // SETTLE: new value active, waiting for one complete period.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } chan_state_e;

  // A zero duty would keep the PWM constantly low and the AFE would never
  // latch a threshold, so zero is stored as the smallest non-zero value.
  function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
    return (v == '0) ? VAL_W'(1) : v;
  endfunction

endpackage

// File: rtl/thresh_pwm_chan.sv
// One threshold channel: pending/active value registers, the
// IDLE/PEND/SETTLE sequencer and the registered PWM compare.
module thresh_pwm_chan
  import thresh_pkg::*;
#(
  parameter logic [VAL_W-1:0] RST_VAL = 8'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary,
  input  logic             accept,
  input  logic [VAL_W-1:0] data,
  output logic             pwm,
  output logic [VAL_W-1:0] act,
  output logic [VAL_W-1:0] eff,
  output logic             idle
);

  chan_state_e      state_q, state_d;
  logic [VAL_W-1:0] pend_q, pend_d;
  logic [VAL_W-1:0] act_q, act_d;
  logic             pwm_q, pwm_d;

  // Next-state logic: transfer on the boundary first, then let an accepted
  // write (possibly on the same cycle) load the pending register.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    pend_d  = pend_q;
    act_d   = act_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = data;
          state_d = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          act_d   = pend_q;
          state_d = SETTLE;
        end
        if (accept) begin
          pend_d  = data;
          state_d = PEND;
        end
      end
      SETTLE: begin
        if (accept) begin
          pend_d  = data;
          state_d = PEND;
        end else if (boundary) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SETTLE;
      end
    endcase

    // High for 4*act clocks of each period; the compare uses the value that
    // is active on this cycle, so the boundary transfer (cnt == max, where
    // the compare is always false) never splits a period.
    pwm_d = (cnt < {act_q, {(CNT_W-VAL_W){1'b0}}});
  end

  // Channel state, value and PWM registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the value registers are ordinary flops with a defined reset
      // value, not a memory, so resetting them is cheap and required here.
      state_q <= SETTLE;
      pend_q  <= RST_VAL;
      act_q   <= RST_VAL;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm  = pwm_q;
  assign act  = act_q;
  assign eff  = (state_q == PEND) ? pend_q : act_q;
  assign idle = (state_q == IDLE);

endmodule

// File: rtl/thresh_pwm_ctrl.sv
// Threshold PWM controller: period counter, VIL < VIH ordering check on
// incoming writes, two channel instances, ready and error flags.
module thresh_pwm_ctrl
  import thresh_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_VIH,
  input  logic [VAL_W-1:0] VIH_data,
  input  logic             wr_VIL,
  input  logic [VAL_W-1:0] VIL_data,
  output logic             VIH_PWM,
  output logic             VIL_PWM,
  output logic [VAL_W-1:0] VIH_cur,
  output logic [VAL_W-1:0] VIL_cur,
  output logic             thresh_rdy,
  output logic             wr_err
);

  logic [CNT_W-1:0] cnt_q;
  logic             boundary;
  logic [VAL_W-1:0] vih_c, vil_c;
  logic [VAL_W-1:0] vih_eff, vil_eff;
  logic             order_ok;
  logic             acc_vih, acc_vil;
  logic             idle_vih, idle_vil;
  logic             rdy_q, err_q;

  assign boundary = (cnt_q == '1);

  // Free-running period counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 1'b1;
  end

  // Ordering check: a lone write is compared to the other channel's
  // effective value, a simultaneous pair is compared against itself.
  always_comb begin
    vih_c    = clamp_val(VIH_data);
    vil_c    = clamp_val(VIL_data);
    order_ok = 1'b0;
    if (wr_VIH && wr_VIL)  order_ok = (vil_c < vih_c);
    else if (wr_VIH)       order_ok = (vih_c > vil_eff);
    else if (wr_VIL)       order_ok = (vil_c < vih_eff);
    acc_vih = wr_VIH && order_ok;
    acc_vil = wr_VIL && order_ok;
  end

  thresh_pwm_chan #(.RST_VAL(VIH_RST)) u_vih (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt_q),
    .boundary (boundary),
    .accept   (acc_vih),
    .data     (vih_c),
    .pwm      (VIH_PWM),
    .act      (VIH_cur),
    .eff      (vih_eff),
    .idle     (idle_vih)
  );

  thresh_pwm_chan #(.RST_VAL(VIL_RST)) u_vil (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt_q),
    .boundary (boundary),
    .accept   (acc_vil),
    .data     (vil_c),
    .pwm      (VIL_PWM),
    .act      (VIL_cur),
    .eff      (vil_eff),
    .idle     (idle_vil)
  );

  // Ready when both channels are settled; an accepted write drops it at
  // once, a rejected one leaves it alone and pulses the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy_q <= idle_vih && idle_vil && !acc_vih && !acc_vil;
      err_q <= (wr_VIH || wr_VIL) && !order_ok;
    end
  end

  assign thresh_rdy = rdy_q;
  assign wr_err     = err_q;

endmodule

// File: tb/tb_thresh_pwm_ctrl.sv
// Self-checking bench for thresh_pwm_ctrl: a period/phase level model of
// the threshold controller compared against the DUT on every cycle, plus
// directed duty, ready and error checks with literal expectations.
module tb_thresh_pwm_ctrl;
  import thresh_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_VIH = 1'b0, wr_VIL = 1'b0;
  logic [7:0] VIH_data = 8'h00, VIL_data = 8'h00;
  logic       VIH_PWM, VIL_PWM, thresh_rdy, wr_err;
  logic [7:0] VIH_cur, VIL_cur;

  int tests = 0;
  int fails = 0;

  thresh_pwm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr_VIH     (wr_VIH),
    .VIH_data   (VIH_data),
    .wr_VIL     (wr_VIL),
    .VIL_data   (VIL_data),
    .VIH_PWM    (VIH_PWM),
    .VIL_PWM    (VIL_PWM),
    .VIH_cur    (VIH_cur),
    .VIL_cur    (VIL_cur),
    .thresh_rdy (thresh_rdy),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = VIH, 1 = VIL. A channel is "busy" from an accepted write
  // until a whole period has run at the new value.
  int  m_phase;            // phase the DUT counter presents on the next edge
  int  m_n;                // edges since reset release
  int  m_act[2];
  int  m_pend[2];
  bit  m_has[2];
  bit  m_busy[2];
  bit  e_pwm[2];
  bit  e_rdy, e_err;
  bit  m_valid = 1'b0;

  function automatic int clampv(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk) begin : model_step
    int dh, dl, effh, effl;
    bit ok, ah, al;
    if (rst) begin
      m_phase = 0; m_n = 0;
      m_act[0] = 'hAA; m_pend[0] = 'hAA;
      m_act[1] = 'h55; m_pend[1] = 'h55;
      m_has[0] = 0; m_has[1] = 0;
      m_busy[0] = 1; m_busy[1] = 1;
      e_pwm[0] = 0; e_pwm[1] = 0;
      e_rdy = 0; e_err = 0;
    end else begin
      dh   = clampv(int'(VIH_data));
      dl   = clampv(int'(VIL_data));
      effh = m_has[0] ? m_pend[0] : m_act[0];
      effl = m_has[1] ? m_pend[1] : m_act[1];
      if (wr_VIH && wr_VIL) ok = (dl < dh);
      else if (wr_VIH)      ok = (dh > effl);
      else if (wr_VIL)      ok = (dl < effh);
      else                  ok = 0;
      ah = wr_VIH && ok;
      al = wr_VIL && ok;
      e_err = (wr_VIH || wr_VIL) && !ok;
      e_rdy = !m_busy[0] && !m_busy[1] && !ah && !al;
      for (int i = 0; i < 2; i++) e_pwm[i] = (m_phase < 4 * m_act[i]);
      if (m_phase == PWM_PERIOD - 1) begin
        for (int i = 0; i < 2; i++) begin
          if (m_has[i]) begin
            m_act[i] = m_pend[i];
            m_has[i] = 0;
            m_busy[i] = 1;
          end else begin
            m_busy[i] = 0;
          end
        end
      end
      if (ah) begin m_pend[0] = dh; m_has[0] = 1; m_busy[0] = 1; end
      if (al) begin m_pend[1] = dl; m_has[1] = 1; m_busy[1] = 1; end
      m_phase = (m_phase + 1) % PWM_PERIOD;
      m_n++;
    end
    m_valid = 1'b1;
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid)
      check("cycle_outputs",
            {12'h0, VIH_PWM, VIL_PWM, thresh_rdy, wr_err, VIH_cur, VIL_cur},
            {12'h0, e_pwm[0], e_pwm[1], e_rdy, e_err, 8'(m_act[0]), 8'(m_act[1])});
  end

  // ---------------- directed helpers ----------------
  // Returns at the negedge where the next edge presents phase c.
  task automatic wait_phase(input int c);
    for (int i = 0; i < 1100 && m_phase != c; i++) @(negedge clk);
    if (m_phase != c) check("wait_phase_timeout", m_phase, c);
  endtask

  task automatic wait_rdy(input int bound);
    for (int i = 0; i < bound && !thresh_rdy; i++) @(negedge clk);
    if (!thresh_rdy) check("wait_rdy_timeout", thresh_rdy, 1);
  endtask

  task automatic do_write(input bit h, input logic [7:0] hv, input bit l, input logic [7:0] lv);
    wr_VIH = h; VIH_data = hv; wr_VIL = l; VIL_data = lv;
    @(negedge clk);
    wr_VIH = 0; wr_VIL = 0;
  endtask

  // Loopback AFE: high clocks of each channel over one whole period.
  task automatic measure(output int hh, output int hl);
    hh = 0; hl = 0;
    wait_phase(1);
    for (int i = 0; i < PWM_PERIOD; i++) begin
      hh += int'(VIH_PWM);
      hl += int'(VIL_PWM);
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hh, hl, r;

    // Reset state.
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset_flags", {VIH_PWM, VIL_PWM, thresh_rdy, wr_err}, 4'b0000);
    check("reset_cur", {VIH_cur, VIL_cur}, 16'hAA55);
    rst = 0;

    // First settle and default duties.
    wait_rdy(1200);
    check("rdy_rise_cycle", m_n, 1025);
    measure(hh, hl);
    check("vih_duty_rst", hh, 680);
    check("vil_duty_rst", hl, 340);
    check("afe_vih_rst", hh / 4, 'hAA);
    check("afe_vil_rst", hl / 4, 'h55);

    // Mid-period VIL write applies at the next period.
    wait_phase(300);
    do_write(0, 8'h00, 1, 8'h40);
    check("vil_rdy_drop", thresh_rdy, 0);
    check("vil_cur_hold", VIL_cur, 8'h55);
    measure(hh, hl);
    check("vil_duty_40", hl, 256);
    check("vih_duty_keep", hh, 680);
    check("vil_cur_40", VIL_cur, 8'h40);

    // Ordering rejection and accepted simultaneous pair.
    wait_rdy(2100);
    do_write(0, 8'h00, 1, 8'hB0);
    check("err_pulse", wr_err, 1);
    check("err_rdy_kept", thresh_rdy, 1);
    @(negedge clk);
    check("err_single", wr_err, 0);
    check("err_cur_hold", VIL_cur, 8'h40);
    do_write(1, 8'hC0, 1, 8'hB0);
    check("pair_no_err", wr_err, 0);
    check("pair_rdy_drop", thresh_rdy, 0);
    wait_phase(1);
    check("pair_cur", {VIH_cur, VIL_cur}, 16'hC0B0);

    // Last write in a period wins; zero write clamps to 1.
    wait_rdy(2100);
    wait_phase(100);
    do_write(1, 8'hE0, 0, 8'h00);
    wait_phase(200);
    do_write(1, 8'hF0, 0, 8'h00);
    measure(hh, hl);
    check("vih_duty_f0", hh, 960);
    check("vih_cur_f0", VIH_cur, 8'hF0);
    do_write(0, 8'h00, 1, 8'h00);
    measure(hh, hl);
    check("vil_duty_clamp", hl, 4);
    check("vil_cur_clamp", VIL_cur, 8'h01);

    // Write on the boundary cycle, then a write during SETTLE.
    wait_rdy(2100);
    wait_phase(1023);
    do_write(0, 8'h00, 1, 8'h30);
    check("bnd_rdy_drop", thresh_rdy, 0);
    check("bnd_cur_hold", VIL_cur, 8'h01);
    wait_phase(1);
    check("bnd_not_applied", VIL_cur, 8'h01);
    wait_phase(0);
    wait_phase(1);
    check("bnd_applied", VIL_cur, 8'h30);
    wait_phase(500);
    do_write(0, 8'h00, 1, 8'h20);
    check("settle_rdy_low", thresh_rdy, 0);
    wait_phase(1);
    check("settle_applied", VIL_cur, 8'h20);
    check("settle_rdy_still_low", thresh_rdy, 0);
    wait_rdy(1100);
    check("settle_rdy_phase", m_phase, 1);

    // Randomized writes, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      wr_VIH   = (r < 3) || (r == 6);
      wr_VIL   = (r >= 3 && r < 6) || (r == 6);
      VIH_data = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      VIL_data = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_VIH = 0; wr_VIL = 0;

    // Reset mid-period with a pending write.
    wait_phase(400);
    do_write(1, 8'hFF, 0, 8'h00);
    check("rst_pend_accepted", wr_err, 0);
    wait_phase(500);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_flags", {VIH_PWM, VIL_PWM, thresh_rdy, wr_err}, 4'b0000);
    check("rst_mid_cur", {VIH_cur, VIL_cur}, 16'hAA55);
    repeat (1030) @(negedge clk);
    check("rst_pend_discarded", {VIH_cur, VIL_cur}, 16'hAA55);
    check("rst_rdy_again", thresh_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
